// File: rtl/pulse_width_meter_if.sv
// Consumer-side bundle for pulse_width_meter: asynchronous pulse in, result handshake out.
interface pulse_width_meter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in;
  logic             ack;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overflow;
  logic             overrun;
  logic             busy;

  modport master (
    output in,
    output ack,
    input  data,
    input  valid,
    input  overflow,
    input  overrun,
    input  busy
  );

  modport slave (
    input  in,
    input  ack,
    output data,
    output valid,
    output overflow,
    output overrun,
    output busy
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures the high-time of an asynchronous input in clk cycles and holds the
// result until the consumer acknowledges it.
module pulse_width_meter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  pulse_width_meter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMeasure, StDone} state_e;

  localparam logic [WIDTH-1:0] CountMax = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_s;
  logic                   in_d;
  logic                   rise;
  logic                   fall;

  logic [1:0]             lvl_p;
  logic [1:0]             rise_p;
  logic [1:0]             fall_p;
  logic                   lvl_e;
  logic                   rise_e;
  logic                   fall_e;

  state_e                 state_q;
  logic [WIDTH-1:0]       count_q;
  logic                   ovf_q;
  logic [WIDTH-1:0]       data_q;
  logic                   valid_q;
  logic                   overflow_q;
  logic                   overrun_q;
  logic                   busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      in_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.in};
      in_d   <= in_s;
    end
  end

  assign in_s = sync_q[SYNC_STAGES-1];
  assign rise = in_s & ~in_d;
  assign fall = ~in_s & in_d;

  // Level and edge strobes are retimed two stages so a result lands
  // SYNC_STAGES+2 edges after the input is first sampled low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_p  <= '0;
      rise_p <= '0;
      fall_p <= '0;
    end else begin
      lvl_p  <= {lvl_p[0], in_s};
      rise_p <= {rise_p[0], rise};
      fall_p <= {fall_p[0], fall};
    end
  end

  assign lvl_e  = lvl_p[1];
  assign rise_e = rise_p[1];
  assign fall_e = fall_p[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise_e) begin
            state_q <= StMeasure;
            count_q <= WIDTH'(1);
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StMeasure: begin
          if (fall_e) begin
            data_q     <= count_q;
            overflow_q <= ovf_q;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StDone;
          end else if (lvl_e) begin
            // Saturate and flag rather than wrap.
            if (count_q == CountMax) begin
              ovf_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        StDone: begin
          // A dropped rise on the acknowledge edge keeps overrun set.
          if (rise_e) begin
            overrun_q <= 1'b1;
          end else if (bus.ack) begin
            overrun_q <= 1'b0;
          end
          if (bus.ack) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;

endmodule
